// File: rtl/spram_req_ctrl.sv
// spram_req_ctrl: valid/ready request front-end serialising reads and writes onto one 8x8 RAM port.
// Define SPRAM_CTRL_INIT_EN to zero the whole RAM with a one-write-per-cycle sweep after reset.
module spram_req_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk_pi,
  input  logic              rst_pi,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              init_done_o
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_CAP  = 3'd3,
    ST_RSP     = 3'd4
  } state_t;

  // Addresses wrap modulo DEPTH; this is also the last address of the init sweep.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);

`ifdef SPRAM_CTRL_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t state_r;
  logic   req_fire_s;

  assign req_ready_o = (state_r == ST_IDLE);
  assign req_fire_s  = req_valid_i & req_ready_o;

`ifdef SPRAM_CTRL_INIT_EN
  logic [ADDR_W-1:0] init_addr_r;
  logic              init_done_r;

  assign init_done_o = init_done_r;
`else
  assign init_done_o = 1'b1;
`endif

  // Request sequencing, RAM command registers and read response registers
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      state_r     <= RESET_STATE;
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_data_o  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
`ifdef SPRAM_CTRL_INIT_EN
      init_addr_r <= '0;
      init_done_r <= 1'b0;
`endif
    end else begin
      // A RAM command lives for exactly one cycle; every other cycle the port is idle.
      ram_en_o <= 1'b0;
      ram_we_o <= 1'b0;
      case (state_r)
`ifdef SPRAM_CTRL_INIT_EN
        ST_INIT: begin
          ram_en_o    <= 1'b1;
          ram_we_o    <= 1'b1;
          ram_addr_o  <= init_addr_r;
          ram_data_o  <= '0;
          init_addr_r <= init_addr_r + ADDR_W'(1);
          if (init_addr_r == ADDR_MASK) begin
            init_done_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_INIT;
          end
        end
`endif
        ST_IDLE: begin
          if (req_fire_s) begin
            ram_en_o   <= 1'b1;
            ram_we_o   <= req_we_i;
            ram_addr_o <= req_addr_i & ADDR_MASK;
            if (req_we_i) begin
              ram_data_o <= req_data_i;
              state_r    <= ST_IDLE;
            end else begin
              state_r    <= ST_RD_WAIT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          state_r <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          rsp_data_o  <= ram_data_i;
          rsp_valid_o <= 1'b1;
          state_r     <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_RSP;
          end
        end
        default: begin
          state_r <= RESET_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Self-checking bench for spram_req_ctrl: a behavioural RAM on the port plus an array reference model.
`timescale 1ns/1ps
module tb_spram_req_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_en;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic          init_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: what each address should hold, and whether it has a defined value yet.
  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];

  always #5 clk = ~clk;

  spram_req_ctrl dut (
    .clk_pi      (clk),
    .rst_pi      (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .ram_addr_o  (ram_addr),
    .ram_data_o  (ram_wdata),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_data_i  (ram_q),
    .init_done_o (init_done)
  );

  // Single-port synchronous RAM the controller drives
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_q <= ram_mem[ram_addr];
    end
  end

  int en_cnt = 0;
  int hs_cnt = 0;
  always @(posedge clk) begin
    if (ram_en === 1'b1) en_cnt <= en_cnt + 1;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = 8'd0;
      known[i] = 1'b1;
    end
  endtask

  // Present one request and hold it until accepted; returns cycles spent waiting for ready.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] v, output int waited);
    waited    = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_data  = v;
    while (req_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (waited >= 50) begin
      failures++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, waited);
    end
    tick();
    if (we) begin
      model[a] = v;
      known[a] = 1'b1;
    end
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = AW'($urandom);
    req_data  = DW'($urandom);
  endtask

  // Called right after a read is accepted; waits for rsp_valid and reports its latency in edges.
  task automatic get_rsp(output logic [DW-1:0] d, output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    d = rsp_data;
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    int nwr;
    int done_at;
    bit order_ok;
    bit ready_ok;
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    obs = {ram_en, ram_we, ram_addr, ram_wdata, rsp_valid, rsp_data};
    checks++;
    if (obs !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %0h expected 0", obs);
    end
    checks++;
`ifdef SPRAM_CTRL_INIT_EN
    if (req_ready !== 1'b0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got ready=%b done=%b expected 0 0", req_ready, init_done);
    end
`else
    if (req_ready !== 1'b1 || init_done !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got ready=%b done=%b expected 1 1", req_ready, init_done);
    end
`endif
    rst = 1'b0;
`ifdef SPRAM_CTRL_INIT_EN
    nwr = 0;
    done_at = -1;
    order_ok = 1'b1;
    ready_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ram_en === 1'b1 && ram_we === 1'b1) begin
        if (ram_addr !== nwr[AW-1:0] || ram_wdata !== 8'd0) order_ok = 1'b0;
        nwr++;
      end
      if (init_done !== 1'b1 && req_ready !== 1'b0) ready_ok = 1'b0;
      if (init_done === 1'b1 && done_at < 0) done_at = i;
    end
    checks++;
    if (nwr != DEPTH || !order_ok) begin
      failures++;
      $display("FAIL init_sweep: got %0d writes order_ok=%0d expected %0d writes in order", nwr, order_ok, DEPTH);
    end
    checks++;
    if (done_at != DEPTH - 1 || !ready_ok) begin
      failures++;
      $display("FAIL init_done: got done at %0d ready_ok=%0d expected %0d", done_at, ready_ok, DEPTH - 1);
    end
    model_clear_all();
`else
    tick();
`endif
    checks++;
    if (req_ready !== 1'b1 || init_done !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready: got ready=%b done=%b expected 1 1", req_ready, init_done);
    end
  endtask

  task automatic test_init_read();
`ifdef SPRAM_CTRL_INIT_EN
    logic [DW-1:0] d;
    int lat;
    int w;
    send(1'b0, 3'd7, 8'd0, w);
    get_rsp(d, lat);
    tick();
    checks++;
    if (d !== 8'd0 || lat != 2) begin
      failures++;
      $display("FAIL init_read7: got data=%0h lat=%0d expected 0 2", d, lat);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    int lat;
    int w;
    int c0;
    c0 = hs_cnt;
    send(1'b1, 3'd1, 8'd4, w);
    send(1'b1, 3'd2, 8'd5, w);
    checks++;
    if (w != 0) begin
      failures++;
      $display("FAIL b2b_write_stall: got %0d wait cycles expected 0", w);
    end
    send(1'b0, 3'd2, 8'd0, w);
    get_rsp(d, lat);
    checks++;
    if (d !== 8'd5 || lat != 2) begin
      failures++;
      $display("FAIL b2b_read: got data=%0h lat=%0d expected 5 2", d, lat);
    end
    repeat (3) tick();
    checks++;
    if (rsp_valid !== 1'b0 || hs_cnt - c0 != 1) begin
      failures++;
      $display("FAIL b2b_rsp_once: got valid=%b handshakes=%0d expected 0 1", rsp_valid, hs_cnt - c0);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    int lat;
    int w;
    bit stable;
    rsp_ready = 1'b0;
    send(1'b0, 3'd1, 8'd0, w);
    get_rsp(d, lat);
    checks++;
    if (d !== 8'd4 || lat != 2) begin
      failures++;
      $display("FAIL bp_read: got data=%0h lat=%0d expected 4 2", d, lat);
    end
    // A request offered while stalled must not be taken.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 3'd1;
    req_data  = 8'hEE;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== 8'd4 || req_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_hold: got valid=%b data=%0h ready=%b expected 1 4 0", rsp_valid, rsp_data, req_ready);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
    end
    send(1'b0, 3'd1, 8'd0, w);
    get_rsp(d, lat);
    tick();
    checks++;
    if (d !== 8'd4) begin
      failures++;
      $display("FAIL bp_stray_ignored: got %0h expected 4", d);
    end
  endtask

  task automatic test_write_then_read();
    logic [DW-1:0] d;
    int lat;
    int w;
    int e0;
    e0 = en_cnt;
    send(1'b1, 3'd3, 8'd6, w);
    send(1'b0, 3'd3, 8'd0, w);
    get_rsp(d, lat);
    checks++;
    if (d !== 8'd6 || lat != 2) begin
      failures++;
      $display("FAIL raw_read: got data=%0h lat=%0d expected 6 2", d, lat);
    end
    repeat (3) tick();
    checks++;
    if (en_cnt - e0 != 2) begin
      failures++;
      $display("FAIL raw_en_pulses: got %0d expected 2", en_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    logic [21:0] obs;
    int lat;
    int w;
    int c0;
    send(1'b1, 3'd5, 8'd8, w);
    send(1'b0, 3'd5, 8'd0, w);
    tick();
    c0 = hs_cnt;
    rst = 1'b1;
    tick();
    obs = {ram_en, ram_we, ram_addr, ram_wdata, rsp_valid, rsp_data};
    checks++;
    if (obs !== 22'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got %0h expected 0", obs);
    end
    rst = 1'b0;
`ifdef SPRAM_CTRL_INIT_EN
    model_clear_all();
`endif
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) tick();
    repeat (3) tick();
    checks++;
    if (rsp_valid !== 1'b0 || hs_cnt != c0) begin
      failures++;
      $display("FAIL midreset_no_rsp: got valid=%b handshakes=%0d expected 0 0", rsp_valid, hs_cnt - c0);
    end
    exp = model[5];
    send(1'b0, 3'd5, 8'd0, w);
    get_rsp(d, lat);
    tick();
    checks++;
    if (d !== exp || lat != 2) begin
      failures++;
      $display("FAIL midreset_reread: got data=%0h lat=%0d expected %0h 2", d, lat, exp);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int lat;
    int w;
    a = 3'd7;
    send(1'b1, a, 8'd9, w);
    a = a + 3'd1;
    send(1'b1, a, 8'd10, w);
    send(1'b0, 3'd7, 8'd0, w);
    get_rsp(d, lat);
    tick();
    checks++;
    if (d !== 8'd9) begin
      failures++;
      $display("FAIL wrap_read7: got %0h expected 9", d);
    end
    send(1'b0, 3'd0, 8'd0, w);
    get_rsp(d, lat);
    tick();
    checks++;
    if (d !== 8'd10) begin
      failures++;
      $display("FAIL wrap_read0: got %0h expected a", d);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    logic [DW-1:0] v;
    logic [AW-1:0] a;
    logic          wr;
    int lat;
    int w;
    int hold;
    bit stable;
    stable = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a  = AW'($urandom_range(0, DEPTH - 1));
      v  = DW'($urandom);
      wr = 1'($urandom_range(0, 1));
      if (!known[a]) wr = 1'b1;
      repeat ($urandom_range(0, 2)) tick();
      if (wr) begin
        send(1'b1, a, v, w);
      end else begin
        exp  = model[a];
        hold = int'($urandom_range(0, 3));
        rsp_ready = (hold == 0);
        send(1'b0, a, 8'd0, w);
        get_rsp(d, lat);
        checks++;
        if (d !== exp || lat != 2) begin
          failures++;
          $display("FAIL rand_read addr=%0d: got data=%0h lat=%0d expected %0h 2", a, d, lat, exp);
        end
        for (int k = 0; k < hold; k++) begin
          tick();
          if (rsp_valid !== 1'b1 || rsp_data !== exp) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        tick();
      end
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL rand_hold: response changed while stalled, expected stable");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = 8'd0;
      known[i] = 1'b0;
    end
    test_reset();
    test_init_read();
    test_back_to_back();
    test_backpressure();
    test_write_then_read();
    test_reset_mid_read();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
